// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serializes valid/ready bitstream words MSB-first into a ccff configuration chain.
// Define CCFF_READBACK_EN to add a lossless readback stream of the old chain contents taken from ccff_tail.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready
`endif
);
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] shift_buf;
    logic [BC_W-1:0]   buf_cnt, take;
    logic [CNT_W-1:0]  accepted, remaining;
    logic              shift_now, stall, accept, load_start, load_end;

    assign busy       = state == LOAD;
    assign done       = state == DONE;
    assign load_start = state == IDLE && start;
    assign shift_now  = busy && buf_cnt != '0 && !stall;
    assign chain_en   = shift_now;
    assign ccff_head  = shift_now && shift_buf[WORD_W-1];
    assign remaining  = LEN - accepted;
    assign take       = (int'(remaining) >= WORD_W) ? BC_W'(WORD_W) : BC_W'(remaining);
    // A new word may land on the same edge that shifts out the last buffered bit.
    assign cfg_ready  = busy && accepted < LEN && (buf_cnt == '0 || (buf_cnt == BC_W'(1) && shift_now));
    assign accept     = cfg_valid && cfg_ready;

    always_comb begin
        state_next = state;
        state_next = load_start ? LOAD : (busy && load_end) ? DONE : done ? IDLE : state;
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state     <= IDLE;
            shift_buf <= '0;
            buf_cnt   <= '0;
            accepted  <= '0;
            bit_count <= '0;
        end else begin
            state <= state_next;
            if (load_start) begin
                buf_cnt   <= '0;
                accepted  <= '0;
                bit_count <= '0;
            end else begin
                if (accept) begin
                    shift_buf <= cfg_data;
                    buf_cnt   <= take;
                    accepted  <= accepted + CNT_W'(take);
                end else if (shift_now) begin
                    shift_buf <= {shift_buf[WORD_W-2:0], 1'b0};
                    buf_cnt   <= buf_cnt - 1'b1;
                end
                if (shift_now)
                    bit_count <= bit_count + 1'b1;
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_sr, rb_next;
    logic [BC_W-1:0]   rb_cnt;
    logic              cap_last;

    assign rb_next  = {rb_sr[WORD_W-2:0], ccff_tail};
    assign cap_last = rb_cnt == BC_W'(WORD_W - 1) || bit_count == LAST;
    // Pause the chain only when the capture would overwrite an untaken readback word.
    assign stall    = rb_valid && !rb_ready && cap_last;
    assign load_end = bit_count == LEN && rb_valid && rb_ready;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_sr    <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else if (load_start) begin
            rb_cnt <= '0;
        end else begin
            if (shift_now) begin
                rb_sr  <= rb_next;
                rb_cnt <= cap_last ? '0 : rb_cnt + 1'b1;
            end
            if (shift_now && cap_last) begin
                rb_data  <= rb_next << (BC_W'(WORD_W - 1) - rb_cnt);
                rb_valid <= 1'b1;
            end else if (rb_ready) begin
                rb_valid <= 1'b0;
            end
        end
    end
`else
    logic tail_unused;

    assign tail_unused = ccff_tail;
    assign stall       = 1'b0;
    assign load_end    = shift_now && bit_count == LAST;
`endif
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: directed checks of the loader with an 8-bit and an 11-bit chain.
// Readback scenario is compiled only when CCFF_READBACK_EN is defined.
module tb_ccff_bitstream_loader;
`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        prog_clk = 1'b0;
    logic        prog_reset = 1'b1;
    logic        start8 = 1'b0, start11 = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_valid = 1'b0;
    logic        rb_ready = 1'b1;
    logic        preload = 1'b0;
    logic        ready8, head8, en8, busy8, done8;
    logic        ready11, head11, en11, busy11, done11;
    logic [3:0]  bc8, bc11;
    logic [7:0]  chain8 = 8'h00;
    logic [10:0] chain11 = 11'h000;
    int          checks = 0;
    int          errors = 0;
`ifdef CCFF_READBACK_EN
    logic [7:0]  rb_data8, rb_data11;
    logic        rb_valid8, rb_valid11;
`endif

    always #5 prog_clk = ~prog_clk;

    // Model chains: element [N-1] is the tail-most flop.
    always @(posedge prog_clk) begin
        if (preload) chain8 <= 8'h3C;
        else if (en8) chain8 <= {chain8[6:0], head8};
        if (en11) chain11 <= {chain11[9:0], head11};
    end

    ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start8),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready8),
        .ccff_head(head8), .chain_en(en8), .ccff_tail(chain8[7]),
        .busy(busy8), .done(done8), .bit_count(bc8)
`ifdef CCFF_READBACK_EN
        , .rb_data(rb_data8), .rb_valid(rb_valid8), .rb_ready(rb_ready)
`endif
    );

    ccff_bitstream_loader #(.CHAIN_LEN(11), .WORD_W(8)) dut11 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start11),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready11),
        .ccff_head(head11), .chain_en(en11), .ccff_tail(chain11[10]),
        .busy(busy11), .done(done11), .bit_count(bc11)
`ifdef CCFF_READBACK_EN
        , .rb_data(rb_data11), .rb_valid(rb_valid11), .rb_ready(rb_ready)
`endif
    );

    task automatic test_reset;
        prog_reset = 1'b1;
        repeat (2) @(negedge prog_clk);
        checks++;
        if ({busy8, done8, en8, head8, ready8} !== 5'b0) begin
            errors++;
            $display("FAIL reset_out8 got %b exp 00000", {busy8, done8, en8, head8, ready8});
        end
        checks++;
        if (bc8 !== 4'd0) begin errors++; $display("FAIL reset_bc8 got %0d exp 0", bc8); end
        checks++;
        if ({busy11, done11, en11, head11, ready11} !== 5'b0) begin
            errors++;
            $display("FAIL reset_out11 got %b exp 00000", {busy11, done11, en11, head11, ready11});
        end
        checks++;
        if (bc11 !== 4'd0) begin errors++; $display("FAIL reset_bc11 got %0d exp 0", bc11); end
        prog_reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] w = 8'hA5;
        logic exp_en, exp_head;
        int exp_bc;
        @(negedge prog_clk) start8 = 1'b1;
        @(negedge prog_clk) start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || ready8 !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept got busy=%b ready=%b exp 1 1", busy8, ready8);
        end
        cfg_data = w;
        cfg_valid = 1'b1;
        for (int c = 2; c <= 11 + RB; c++) begin
            @(negedge prog_clk);
            exp_en = c <= 9;
            exp_head = exp_en ? w[9-c] : 1'b0;
            exp_bc = c <= 9 ? c - 2 : 8;
            checks++;
            if (en8 !== exp_en || head8 !== exp_head) begin
                errors++;
                $display("FAIL basic_shift c=%0d got en=%b head=%b exp en=%b head=%b", c, en8, head8, exp_en, exp_head);
            end
            checks++;
            if (bc8 !== 4'(exp_bc) || ready8 !== 1'b0) begin
                errors++;
                $display("FAIL basic_count c=%0d got bc=%0d ready=%b exp bc=%0d ready=0", c, bc8, ready8, exp_bc);
            end
            checks++;
            if (done8 !== (c == 10 + RB) || busy8 !== (c <= 9 + RB)) begin
                errors++;
                $display("FAIL basic_done c=%0d got done=%b busy=%b", c, done8, busy8);
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (chain8 !== w) begin errors++; $display("FAIL basic_chain got %h exp %h", chain8, w); end
    endtask

    task automatic test_partial;
        logic [10:0] p = {8'hFF, 3'b110};
        logic exp_en, exp_head;
        int exp_bc;
        @(negedge prog_clk) start11 = 1'b1;
        @(negedge prog_clk) start11 = 1'b0;
        cfg_data = 8'hFF;
        cfg_valid = 1'b1;
        for (int c = 2; c <= 14 + RB; c++) begin
            @(negedge prog_clk);
            cfg_data = 8'hC0;
            exp_en = c <= 12;
            exp_head = exp_en ? p[12-c] : 1'b0;
            exp_bc = c <= 12 ? c - 2 : 11;
            checks++;
            if (en11 !== exp_en || head11 !== exp_head) begin
                errors++;
                $display("FAIL partial_shift c=%0d got en=%b head=%b exp en=%b head=%b", c, en11, head11, exp_en, exp_head);
            end
            checks++;
            if (bc11 !== 4'(exp_bc) || ready11 !== (c == 9)) begin
                errors++;
                $display("FAIL partial_count c=%0d got bc=%0d ready=%b exp bc=%0d ready=%b", c, bc11, ready11, exp_bc, c == 9);
            end
            checks++;
            if (done11 !== (c == 13 + RB)) begin
                errors++;
                $display("FAIL partial_done c=%0d got %b exp %b", c, done11, c == 13 + RB);
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (chain11 !== p) begin errors++; $display("FAIL partial_chain got %h exp %h", chain11, p); end
    endtask

    task automatic test_starvation;
        logic [10:0] p = {8'hFF, 3'b101};
        logic exp_en, exp_head;
        int exp_bc;
        @(negedge prog_clk) start11 = 1'b1;
        @(negedge prog_clk) start11 = 1'b0;
        cfg_data = 8'hFF;
        cfg_valid = 1'b1;
        for (int c = 2; c <= 17 + RB; c++) begin
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            exp_en = c <= 9 || (c >= 13 && c <= 15);
            exp_head = c <= 9 ? p[12-c] : exp_en ? p[15-c] : 1'b0;
            exp_bc = c <= 9 ? c - 2 : c <= 12 ? 8 : c <= 15 ? c - 5 : 11;
            checks++;
            if (en11 !== exp_en || head11 !== exp_head) begin
                errors++;
                $display("FAIL starve_shift c=%0d got en=%b head=%b exp en=%b head=%b", c, en11, head11, exp_en, exp_head);
            end
            checks++;
            if (bc11 !== 4'(exp_bc) || done11 !== (c == 16 + RB)) begin
                errors++;
                $display("FAIL starve_count c=%0d got bc=%0d done=%b exp bc=%0d done=%b", c, bc11, done11, exp_bc, c == 16 + RB);
            end
            if (c >= 10 && c <= 12) begin
                checks++;
                if (ready11 !== 1'b1) begin errors++; $display("FAIL starve_ready c=%0d got %b exp 1", c, ready11); end
            end
            if (c == 12) begin
                cfg_data = 8'hA0;
                cfg_valid = 1'b1;
            end
        end
        checks++;
        if (chain11 !== p) begin errors++; $display("FAIL starve_chain got %h exp %h", chain11, p); end
    endtask

    task automatic test_reset_mid;
        @(negedge prog_clk) start8 = 1'b1;
        @(negedge prog_clk) start8 = 1'b0;
        cfg_data = 8'hFF;
        cfg_valid = 1'b1;
        repeat (5) @(negedge prog_clk) cfg_valid = 1'b0;
        checks++;
        if (bc8 !== 4'd4) begin errors++; $display("FAIL midrst_pre got bc=%0d exp 4", bc8); end
        prog_reset = 1'b1;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        checks++;
        if ({busy8, done8, en8, head8, ready8} !== 5'b0 || bc8 !== 4'd0) begin
            errors++;
            $display("FAIL midrst_out got %b bc=%0d exp 00000 bc=0", {busy8, done8, en8, head8, ready8}, bc8);
        end
        start8 = 1'b1;
        @(negedge prog_clk) start8 = 1'b0;
        cfg_data = 8'h5A;
        cfg_valid = 1'b1;
        @(negedge prog_clk) cfg_valid = 1'b0;
        checks++;
        if (bc8 !== 4'd0 || en8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart got bc=%0d en=%b exp bc=0 en=1", bc8, en8);
        end
        repeat (8 + RB) @(negedge prog_clk);
        checks++;
        if (done8 !== 1'b1 || bc8 !== 4'd8) begin
            errors++;
            $display("FAIL midrst_done got done=%b bc=%0d exp done=1 bc=8", done8, bc8);
        end
        checks++;
        if (chain8 !== 8'h5A) begin errors++; $display("FAIL midrst_chain got %h exp 5a", chain8); end
    endtask

    task automatic test_start_ignored;
        int exp_bc;
        @(negedge prog_clk) start8 = 1'b1;
        @(negedge prog_clk) start8 = 1'b0;
        cfg_data = 8'h96;
        cfg_valid = 1'b1;
        for (int c = 2; c <= 12 + RB; c++) begin
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            exp_bc = c <= 9 ? c - 2 : 8;
            checks++;
            if (bc8 !== 4'(exp_bc) || busy8 !== (c <= 9 + RB) || done8 !== (c == 10 + RB)) begin
                errors++;
                $display("FAIL ignstart c=%0d got bc=%0d busy=%b done=%b exp bc=%0d", c, bc8, busy8, done8, exp_bc);
            end
            start8 = c == 4 || c == 10 + RB;
        end
        start8 = 1'b0;
        checks++;
        if (chain8 !== 8'h96) begin errors++; $display("FAIL ignstart_chain got %h exp 96", chain8); end
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback;
        @(negedge prog_clk) preload = 1'b1;
        @(negedge prog_clk) preload = 1'b0;
        rb_ready = 1'b0;
        start8 = 1'b1;
        @(negedge prog_clk) start8 = 1'b0;
        cfg_data = 8'h00;
        cfg_valid = 1'b1;
        for (int c = 2; c <= 16; c++) begin
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            if (c >= 10 && c <= 14) begin
                checks++;
                if (rb_valid8 !== 1'b1 || en8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL rb_hold c=%0d got rbv=%b en=%b done=%b busy=%b", c, rb_valid8, en8, done8, busy8);
                end
            end
            if (c == 15) begin
                checks++;
                if (rb_data8 !== 8'h3C) begin errors++; $display("FAIL rb_data got %h exp 3c", rb_data8); end
                rb_ready = 1'b1;
            end
            if (c == 16) begin
                checks++;
                if (done8 !== 1'b1 || rb_valid8 !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_done got done=%b rbv=%b exp 1 0", done8, rb_valid8);
                end
            end
        end
        checks++;
        if (chain8 !== 8'h00) begin errors++; $display("FAIL rb_chain got %h exp 00", chain8); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_starvation();
        test_reset_mid();
        test_start_ignored();
`ifdef CCFF_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
